sniff_log_reader: RTL and testbench
===================================

Name: sniff_log_reader

Overview:
- Downstream of the sniffer capture path, which writes 64-bit SPI sniffer records into DRAM as two consecutive 32-bit words.
- On a host command, reads a word range back from DRAM through the shared DRAM request port.
- Streams the words as bytes to the UART transmitter, inserting a sync byte before each record.
- Used to dump captured SPI flash traffic after a trigger.

Parameters:
- ADDR_W, 24, DRAM word-address width; matches the dram_addr bus.
- SYNC_BYTE, 8'hA5, marker byte emitted before each record.
- WORDS_PER_REC, 2, DRAM words per sniffer record.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command pulse; ignored while busy=1.
- start_addr  in  ADDR_W  first word address to read; sampled on start.
- end_addr  in  ADDR_W  exclusive end word address; sampled on start.
- abort  in  1  level or pulse; stops the dump at the next safe point.
- dram_req  out  1  DRAM read request.
- dram_addr  out  ADDR_W  word address; stable while dram_req=1.
- dram_we  out  1  tied 0; this block only reads.
- dram_idata  in  32  read data; valid in the dram_ack cycle.
- dram_ack  in  1  one-cycle acknowledge from the DRAM arbiter.
- tx_data  out  8  byte to the UART.
- tx_stb  out  1  one-cycle byte strobe.
- tx_busy  in  1  UART busy flag.
- busy  out  1  high from the cycle after an accepted start until the cycle done pulses.
- done  out  1  one-cycle pulse at the end of a dump (normal completion or abort).

Behaviour:
- Reset values: dram_req=0, dram_addr=0, dram_we=0, tx_stb=0, tx_data=0, busy=0, done=0. The FSM goes to IDLE. Reset mid-operation drops dram_req immediately with no completion.
- State IDLE:
  - start with start_addr==end_addr → DONE; no DRAM access, no bytes sent.
  - start otherwise → latch cur_addr=start_addr, end_addr, word_idx=0; go to REQ.
- State REQ:
  - dram_req=1, dram_addr=cur_addr.
  - On dram_ack: latch dram_idata into data_reg, drop dram_req the next cycle, cur_addr <= cur_addr+1 modulo 2^ADDR_W.
  - Next state is SYNC if word_idx==0, else SEND with byte_idx=0.
- State SYNC:
  - When tx_busy=0: tx_data=SYNC_BYTE, tx_stb=1 for one cycle; go to GAP, returning to SEND with byte_idx=0.
- State SEND:
  - When tx_busy=0: tx_data = data_reg byte byte_idx (byte 0 = [7:0] ... byte 3 = [31:24], LSB first), tx_stb=1; go to GAP.
- State GAP:
  - Exactly one cycle, so the UART can raise tx_busy; tx_busy is not sampled in the strobe cycle.
  - Then the FSM returns to SEND with byte_idx+1, or to word-end handling after byte 3.
- Word end:
  - word_idx <= (word_idx+1) mod WORDS_PER_REC.
  - cur_addr==end_addr → DONE; else abort seen → DONE; else → REQ.
- State DONE: done=1 for one cycle, busy=0 in the same cycle; → IDLE.
- Abort:
  - Latched into a sticky flag while busy; the flag clears in IDLE.
  - Never drops dram_req before ack. The current word always finishes transmitting, then DONE.
  - Abort in IDLE has no effect.
- Range and wrap:
  - Addresses wrap modulo 2^ADDR_W.
  - The end test is equality only, so start_addr > end_addr reads across the wrap.
  - A range that is not a multiple of WORDS_PER_REC is allowed; the last record is partial and gets no padding.
- Latency:
  - REQ asserts in the cycle after start.
  - First tx_stb (SYNC) comes 1 cycle after ack if tx_busy=0.
  - Minimum spacing between strobes is 2 cycles.
- Simultaneous events: start and abort in the same IDLE cycle means start is accepted and abort is ignored. start while busy is ignored.

Decomposition:
- Shared package: FSM state encoding (IDLE, REQ, SYNC, SEND, GAP, DONE), SYNC_BYTE default, ADDR_W default, DRAM word width constant (32).
- One sub-module: sniff_byte_tx. It takes a 32-bit word plus a sync request, walks the bytes LSB first, and handles the tx_stb/tx_busy/GAP handshake. It returns a word_done pulse. The top level keeps the DRAM FSM, the address counter, and the abort/done logic.

Test Plan:
- Single record: start_addr=0x000010, end_addr=0x000012, DRAM[0x10]=0x44332211, DRAM[0x11]=0x88776655, tx_busy idle → bytes A5,11,22,33,44,55,66,77,88. Exactly 2 requests at 0x10 and 0x11, then done pulse, busy=0.
- Empty range: start_addr=end_addr=0x000100 → done pulse 2 cycles after start, no dram_req, no tx_stb.
- Wrap: start_addr=0xFFFFFF, end_addr=0x000001 → requests at 0xFFFFFF then 0x000000; 9 bytes total; first byte is A5, no A5 before the second word.
- Back-pressure: tx_busy held high for 20 cycles after each strobe and ack delayed 7 cycles → same byte sequence as the single-record case. tx_stb is never asserted while tx_busy=1. dram_addr is stable for the full request.
- Abort during REQ: start 0x20..0x28, abort pulsed while waiting for ack of 0x21 → that word completes (A5 + 4 + 4 bytes in total), no request at 0x22, done pulse.
- Reset mid-SEND, then start 0x30..0x32 → outputs at reset values the cycle after reset; the new dump runs cleanly, beginning with A5.

Source files
------------

// File: rtl/sniff_log_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sniff_log_reader_pkg
// Purpose  : Shared state encoding and constants for the sniffer log reader.
// Revision : 1.0 - initial release
// ============================================================================
package sniff_log_reader_pkg;

    localparam int         c_ADDR_W        = 24;
    localparam logic [7:0] c_SYNC_BYTE     = 8'hA5;
    localparam int         c_DWORD_W       = 32;
    localparam int         c_WORDS_PER_REC = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_SYNC = 3'd2,
        ST_SEND = 3'd3,
        ST_GAP  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // Byte 0 is bits [7:0]; bytes leave the word LSB first.
    function automatic logic [7:0] word_byte(input logic [c_DWORD_W-1:0] word,
                                             input logic [1:0]           idx);
        word_byte = word[{idx, 3'b000} +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sniff_log_reader_byte_tx.sv
`default_nettype none
// ============================================================================
// Module   : sniff_byte_tx
// Purpose  : Serialises one DRAM word (optionally preceded by a sync byte)
//            to the UART using a strobe / one-cycle gap / busy handshake.
// Revision : 1.0 - initial release
// ============================================================================
module sniff_byte_tx
    import sniff_log_reader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = c_SYNC_BYTE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_sync,
    input  logic [c_DWORD_W-1:0] i_word,
    input  logic                 i_tx_busy,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_stb,
    output logic                 o_word_done
);

    state_t               r_state;
    logic [c_DWORD_W-1:0] r_word;
    logic [1:0]           r_byte_idx;
    logic                 r_is_sync;
    logic [7:0]           r_tx_data;
    logic                 r_tx_stb;
    logic                 r_word_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_word      <= '0;
            r_byte_idx  <= '0;
            r_is_sync   <= 1'b0;
            r_tx_data   <= '0;
            r_tx_stb    <= 1'b0;
            r_word_done <= 1'b0;
        end else begin
            r_tx_stb    <= 1'b0;
            r_word_done <= 1'b0;
            case (r_state)
                // A free UART gets the first byte in the cycle right after load.
                ST_IDLE: begin
                    if (i_load) begin
                        r_word     <= i_word;
                        r_byte_idx <= '0;
                        r_is_sync  <= i_sync;
                        if (!i_tx_busy) begin
                            r_tx_data <= i_sync ? SYNC_BYTE : i_word[7:0];
                            r_tx_stb  <= 1'b1;
                            r_state   <= ST_GAP;
                        end else begin
                            r_state <= i_sync ? ST_SYNC : ST_SEND;
                        end
                    end
                end
                ST_SYNC: begin
                    if (!i_tx_busy) begin
                        r_tx_data <= SYNC_BYTE;
                        r_tx_stb  <= 1'b1;
                        r_state   <= ST_GAP;
                    end
                end
                ST_SEND: begin
                    if (!i_tx_busy) begin
                        r_tx_data <= word_byte(r_word, r_byte_idx);
                        r_tx_stb  <= 1'b1;
                        r_is_sync <= 1'b0;
                        r_state   <= ST_GAP;
                    end
                end
                // Strobe cycle: the UART raises busy here, so busy is not looked at.
                ST_GAP: begin
                    if (r_is_sync) begin
                        r_state <= ST_SEND;
                    end else if (r_byte_idx == 2'd3) begin
                        r_word_done <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_state    <= ST_SEND;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_tx_data   = r_tx_data;
    assign o_tx_stb    = r_tx_stb;
    assign o_word_done = r_word_done;

endmodule
`default_nettype wire

// File: rtl/sniff_log_reader.sv
`default_nettype none
// ============================================================================
// Module   : sniff_log_reader
// Purpose  : Reads a captured sniffer word range from DRAM and dumps it to
//            the UART as bytes, with a sync marker ahead of every record.
// Revision : 1.0 - initial release
// ============================================================================
module sniff_log_reader
    import sniff_log_reader_pkg::*;
#(
    parameter int         ADDR_W        = c_ADDR_W,
    parameter logic [7:0] SYNC_BYTE     = c_SYNC_BYTE,
    parameter int         WORDS_PER_REC = c_WORDS_PER_REC
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    start_addr,
    input  logic [ADDR_W-1:0]    end_addr,
    input  logic                 abort,
    output logic                 dram_req,
    output logic [ADDR_W-1:0]    dram_addr,
    output logic                 dram_we,
    input  logic [c_DWORD_W-1:0] dram_idata,
    input  logic                 dram_ack,
    output logic [7:0]           tx_data,
    output logic                 tx_stb,
    input  logic                 tx_busy,
    output logic                 busy,
    output logic                 done
);

    localparam int c_WIDX_W = (WORDS_PER_REC > 1) ? $clog2(WORDS_PER_REC) : 1;
    localparam logic [c_WIDX_W-1:0] c_WIDX_LAST = c_WIDX_W'(WORDS_PER_REC - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cur_addr;
    logic [ADDR_W-1:0]   r_end_addr;
    logic [c_WIDX_W-1:0] r_word_idx;
    logic                r_abort_seen;
    logic                r_dram_req;
    logic [ADDR_W-1:0]   r_dram_addr;
    logic                r_busy;
    logic                r_done;

    logic w_load;
    logic w_sync;
    logic w_word_done;

    assign w_load = (r_state == ST_REQ) && dram_ack;
    assign w_sync = (r_word_idx == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cur_addr   <= '0;
            r_end_addr   <= '0;
            r_word_idx   <= '0;
            r_abort_seen <= 1'b0;
            r_dram_req   <= 1'b0;
            r_dram_addr  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != ST_IDLE && abort)
                r_abort_seen <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_abort_seen <= 1'b0;
                    if (start) begin
                        r_busy     <= 1'b1;
                        r_end_addr <= end_addr;
                        r_word_idx <= '0;
                        if (start_addr == end_addr) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_cur_addr  <= start_addr;
                            r_dram_req  <= 1'b1;
                            r_dram_addr <= start_addr;
                            r_state     <= ST_REQ;
                        end
                    end
                end
                // The request is held until ack even if abort arrives.
                ST_REQ: begin
                    if (dram_ack) begin
                        r_dram_req <= 1'b0;
                        r_cur_addr <= r_cur_addr + ADDR_W'(1);
                        r_state    <= ST_SEND;
                    end
                end
                // Word in flight through the byte serialiser.
                ST_SEND: begin
                    if (w_word_done) begin
                        r_word_idx <= (r_word_idx == c_WIDX_LAST) ? '0
                                      : r_word_idx + c_WIDX_W'(1);
                        if (r_cur_addr == r_end_addr || r_abort_seen || abort) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_dram_req  <= 1'b1;
                            r_dram_addr <= r_cur_addr;
                            r_state     <= ST_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    sniff_byte_tx #(
        .SYNC_BYTE (SYNC_BYTE)
    ) u_byte_tx (
        .clk         (clk),
        .rst         (reset),
        .i_load      (w_load),
        .i_sync      (w_sync),
        .i_word      (dram_idata),
        .i_tx_busy   (tx_busy),
        .o_tx_data   (tx_data),
        .o_tx_stb    (tx_stb),
        .o_word_done (w_word_done)
    );

    assign dram_req  = r_dram_req;
    assign dram_addr = r_dram_addr;
    assign dram_we   = 1'b0;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sniff_log_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sniff_log_reader
// Purpose  : Directed self-checking bench with DRAM and UART models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sniff_log_reader;

    localparam int c_AW = 24;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [c_AW-1:0] start_addr = '0;
    logic [c_AW-1:0] end_addr = '0;
    logic            dram_req;
    logic [c_AW-1:0] dram_addr;
    logic            dram_we;
    logic [31:0]     dram_idata = '0;
    logic            dram_ack = 1'b0;
    logic [7:0]      tx_data;
    logic            tx_stb;
    logic            tx_busy = 1'b0;
    logic            busy;
    logic            done;

    sniff_log_reader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .abort      (abort),
        .dram_req   (dram_req),
        .dram_addr  (dram_addr),
        .dram_we    (dram_we),
        .dram_idata (dram_idata),
        .dram_ack   (dram_ack),
        .tx_data    (tx_data),
        .tx_stb     (tx_stb),
        .tx_busy    (tx_busy),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Models and logs
    logic [31:0]     mem [logic [c_AW-1:0]];
    logic [7:0]      rx_q [$];
    logic [c_AW-1:0] req_q [$];
    int  cyc = 0;
    int  ack_delay = 0;
    bit  bp_mode = 0;
    int  busy_cnt = 0;
    int  req_cnt = 0;
    bit  ack_given = 0;
    logic [c_AW-1:0] req_addr0 = '0;
    int  stb_busy_err = 0;
    int  addr_unstable = 0;
    int  done_cnt = 0;
    int  first_ack = -1;
    int  first_stb = -1;

    function automatic logic [31:0] mem_rd(input logic [c_AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hDEADBEEF;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // DRAM arbiter: ack after ack_delay cycles of a held request
    always @(negedge clk) begin
        dram_ack = 1'b0;
        if (dram_req && !ack_given) begin
            if (req_cnt == 0) begin
                req_q.push_back(dram_addr);
                req_addr0 = dram_addr;
            end else if (dram_addr != req_addr0) begin
                addr_unstable++;
            end
            if (req_cnt == ack_delay) begin
                dram_ack   = 1'b1;
                dram_idata = mem_rd(dram_addr);
                ack_given  = 1'b1;
                if (first_ack < 0) first_ack = cyc;
            end
            req_cnt++;
        end
        if (!dram_req) begin
            req_cnt   = 0;
            ack_given = 1'b0;
        end
    end

    // UART: optional 20-cycle busy after each strobe
    always @(negedge clk) begin
        if (tx_stb) begin
            if (tx_busy) stb_busy_err++;
            rx_q.push_back(tx_data);
            if (first_stb < 0) first_stb = cyc;
            if (bp_mode) busy_cnt = 20;
        end
        if (busy_cnt > 0) begin
            tx_busy = 1'b1;
            busy_cnt--;
        end else begin
            tx_busy = 1'b0;
        end
        if (done) done_cnt++;
    end

    task automatic clear_logs();
        rx_q.delete();
        req_q.delete();
        stb_busy_err  = 0;
        addr_unstable = 0;
        done_cnt      = 0;
        first_ack     = -1;
        first_stb     = -1;
    endtask

    task automatic wait_done(input string tag, input int max);
        int waited = 0;
        while (!done && waited < max) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    endtask

    // exp holds 9 bytes, first transmitted byte in the top byte
    task automatic check_stream(input string tag, input logic [71:0] exp);
        logic [7:0] got;
        chk({tag, "_nbytes"}, 32'(rx_q.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hXX;
            chk($sformatf("%s_byte%0d", tag, i), 32'(got), 32'(exp[8*(8-i) +: 8]));
        end
    endtask

    task automatic check_reqs(input string tag, input logic [c_AW-1:0] a0,
                              input logic [c_AW-1:0] a1);
        chk({tag, "_nreq"}, 32'(req_q.size()), 32'd2);
        chk({tag, "_req0"}, 32'(req_q.size() > 0 ? req_q[0] : '1), 32'(a0));
        chk({tag, "_req1"}, 32'(req_q.size() > 1 ? req_q[1] : '1), 32'(a1));
    endtask

    task automatic pulse_start(input logic [c_AW-1:0] s, input logic [c_AW-1:0] e);
        start_addr = s;
        end_addr   = e;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_dram_req"}, 32'(dram_req), 32'd0);
        chk({tag, "_dram_addr"}, 32'(dram_addr), 32'd0);
        chk({tag, "_dram_we"}, 32'(dram_we), 32'd0);
        chk({tag, "_tx_stb"}, 32'(tx_stb), 32'd0);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int guard;
        mem[24'h000010] = 32'h44332211;
        mem[24'h000011] = 32'h88776655;
        mem[24'hFFFFFF] = 32'hDDCCBBAA;
        mem[24'h000000] = 32'h04030201;
        mem[24'h000020] = 32'h0D0C0B0A;
        mem[24'h000021] = 32'h1D1C1B1A;
        mem[24'h000030] = 32'h34333231;
        mem[24'h000031] = 32'h38373635;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single record, idle UART
        clear_logs();
        pulse_start(24'h000010, 24'h000012);
        chk("single_req_latency", 32'(dram_req), 32'd1);
        chk("single_busy_after_start", 32'(busy), 32'd1);
        chk("single_req_addr", 32'(dram_addr), 32'h10);
        wait_done("single", 300);
        check_stream("single", 72'hA5_11_22_33_44_55_66_77_88);
        check_reqs("single", 24'h000010, 24'h000011);
        chk("single_first_stb_latency", 32'(first_stb - first_ack), 32'd1);

        // Empty range: done two cycles after start, nothing else
        clear_logs();
        pulse_start(24'h000100, 24'h000100);
        chk("empty_busy_c1", 32'(busy), 32'd1);
        chk("empty_done_c1", 32'(done), 32'd0);
        @(negedge clk);
        chk("empty_done_c2", 32'(done), 32'd1);
        chk("empty_busy_c2", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        chk("empty_nreq", 32'(req_q.size()), 32'd0);
        chk("empty_nbytes", 32'(rx_q.size()), 32'd0);
        chk("empty_done_count", 32'(done_cnt), 32'd1);

        // Address wrap
        clear_logs();
        pulse_start(24'hFFFFFF, 24'h000001);
        wait_done("wrap", 300);
        check_stream("wrap", 72'hA5_AA_BB_CC_DD_01_02_03_04);
        check_reqs("wrap", 24'hFFFFFF, 24'h000000);

        // Back-pressure and slow ack
        clear_logs();
        bp_mode   = 1;
        ack_delay = 7;
        pulse_start(24'h000010, 24'h000012);
        wait_done("bp", 2000);
        check_stream("bp", 72'hA5_11_22_33_44_55_66_77_88);
        check_reqs("bp", 24'h000010, 24'h000011);
        chk("bp_stb_while_busy", 32'(stb_busy_err), 32'd0);
        chk("bp_addr_unstable", 32'(addr_unstable), 32'd0);
        bp_mode = 0;
        repeat (25) @(negedge clk);

        // Abort while waiting for the ack of the second word
        clear_logs();
        pulse_start(24'h000020, 24'h000028);
        guard = 0;
        while (!(dram_req && dram_addr == 24'h000021) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("abort_reached_req21", 32'(dram_req && dram_addr == 24'h000021), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_keeps_req", 32'(dram_req), 32'd1);
        wait_done("abort", 300);
        check_stream("abort", 72'hA5_0A_0B_0C_0D_1A_1B_1C_1D);
        check_reqs("abort", 24'h000020, 24'h000021);
        ack_delay = 0;

        // Reset in the middle of byte transmission
        clear_logs();
        bp_mode = 1;
        pulse_start(24'h000010, 24'h000012);
        repeat (30) @(negedge clk);
        chk("midreset_in_progress", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_outputs("midreset");
        bp_mode = 0;
        repeat (25) @(negedge clk);
        chk("midreset_no_done", 32'(done_cnt), 32'd0);
        clear_logs();
        pulse_start(24'h000030, 24'h000032);
        wait_done("after_reset", 300);
        check_stream("after_reset", 72'hA5_31_32_33_34_35_36_37_38);
        check_reqs("after_reset", 24'h000030, 24'h000031);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
